// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage.
//   - default and legal ranges for the data width and register-id width
//   - FSM state encoding used by wb_stage
//   - load funct3 encodings used by load_formatter
package wb_stage_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int XLEN_MIN   = 32;
  localparam int XLEN_MAX   = 64;
  localparam int REG_AW_DEF = 5;
  localparam int REG_AW_MIN = 1;
  localparam int REG_AW_MAX = 6;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    LOAD_WAIT = 2'd2
  } wb_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_load_formatter.sv
// load_formatter: combinational extraction and sign/zero extension of a
// load result from the raw data-bus read word.
// Ports:
//   funct3  - load type (LB/LH/LW/LBU/LHU; other codes pass the word)
//   addr_lo - load address bits [1:0]; bit 0 is ignored for halfwords
//   rdata   - raw read word from the data bus
//   data    - formatted value to write to the register file
module load_formatter
  import wb_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
      F3_LW:   data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: write-back stage. Captures one instruction per cycle from MEM,
// writes ALU results the following cycle, and holds the pipeline while a
// load waits for its data-bus response.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | nothing to write; ready to capture from MEM
//   WRITE     | registered write/retire presented this cycle; ready to capture
//   LOAD_WAIT | load captured, waiting for dbus_rvalid; MEM is stalled
//
// Ports:
//   clk, rst                     - clock, async active-high reset
//   mem_valid .. mem_addr_lo     - instruction presented by MEM
//   dbus_rvalid, dbus_rdata      - data-bus read response
//   wb_stall                     - holds MEM and earlier stages
//   reg_write/regid/writedata    - register-file write port
//   wb_retire                    - one-cycle pulse per retired instruction
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_regid,
  input  logic [XLEN-1:0]   mem_alu_result,
  input  logic              mem_load,
  input  logic [2:0]        mem_load_funct3,
  input  logic [1:0]        mem_addr_lo,
  input  logic              dbus_rvalid,
  input  logic [XLEN-1:0]   dbus_rdata,
  output logic              wb_stall,
  output logic              reg_write,
  output logic [REG_AW-1:0] reg_regid,
  output logic [XLEN-1:0]   reg_writedata,
  output logic              wb_retire
);

  wb_state_e         state_q, state_d;

  // Pending load context, kept apart from the output registers so that
  // reg_regid/reg_writedata hold their last values while the load waits.
  logic              pend_rw_q, pend_rw_d;
  logic [REG_AW-1:0] pend_regid_q, pend_regid_d;
  logic [2:0]        pend_f3_q, pend_f3_d;
  logic [1:0]        pend_lo_q, pend_lo_d;

  logic              reg_write_q, reg_write_d;
  logic              retire_q, retire_d;
  logic [REG_AW-1:0] regid_q, regid_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;

  logic [XLEN-1:0]   load_data;

  load_formatter #(.XLEN(XLEN)) u_fmt (
    .funct3  (pend_f3_q),
    .addr_lo (pend_lo_q),
    .rdata   (dbus_rdata),
    .data    (load_data)
  );

  always_comb begin
    state_d      = state_q;
    pend_rw_d    = pend_rw_q;
    pend_regid_d = pend_regid_q;
    pend_f3_d    = pend_f3_q;
    pend_lo_d    = pend_lo_q;
    reg_write_d  = 1'b0;
    retire_d     = 1'b0;
    regid_d      = regid_q;
    wdata_d      = wdata_q;

    case (state_q)
      IDLE, WRITE: begin
        state_d = IDLE;
        if (mem_valid) begin
          if (mem_load) begin
            state_d      = LOAD_WAIT;
            pend_rw_d    = mem_reg_write;
            pend_regid_d = mem_regid;
            pend_f3_d    = mem_load_funct3;
            pend_lo_d    = mem_addr_lo;
          end else begin
            state_d     = WRITE;
            reg_write_d = mem_reg_write && (mem_regid != '0);
            retire_d    = 1'b1;
            regid_d     = mem_regid;
            wdata_d     = mem_alu_result;
          end
        end
      end
      LOAD_WAIT: begin
        if (dbus_rvalid) begin
          state_d     = WRITE;
          reg_write_d = pend_rw_q && (pend_regid_q != '0);
          retire_d    = 1'b1;
          regid_d     = pend_regid_q;
          wdata_d     = load_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pend_rw_q    <= 1'b0;
      pend_regid_q <= '0;
      pend_f3_q    <= '0;
      pend_lo_q    <= '0;
      reg_write_q  <= 1'b0;
      retire_q     <= 1'b0;
      regid_q      <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      pend_rw_q    <= pend_rw_d;
      pend_regid_q <= pend_regid_d;
      pend_f3_q    <= pend_f3_d;
      pend_lo_q    <= pend_lo_d;
      reg_write_q  <= reg_write_d;
      retire_q     <= retire_d;
      regid_q      <= regid_d;
      wdata_q      <= wdata_d;
    end
  end

  assign wb_stall      = (state_q == LOAD_WAIT);
  assign reg_write     = reg_write_q;
  assign wb_retire     = retire_q;
  assign reg_regid     = regid_q;
  assign reg_writedata = wdata_q;

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width.
REQ-002 SHALL have parameter REG_AW, default 5, register-id width.
REQ-003 SHALL have port clk  input  1  single clock; all state on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port mem_valid  input  1  MEM stage presents an instruction.
REQ-006 SHALL have port mem_reg_write  input  1  instruction writes rd.
REQ-007 SHALL have port mem_regid  input  REG_AW  rd index.
REQ-008 SHALL have port mem_alu_result  input  XLEN  non-load result.
REQ-009 SHALL have port mem_load  input  1  instruction is a load.
REQ-010 SHALL have port mem_load_funct3  input  3  load type (LB/LH/LW/LBU/LHU).
REQ-011 SHALL have port mem_addr_lo  input  2  load address bits [1:0].
REQ-012 SHALL have port dbus_rvalid  input  1  data-bus read response valid.
REQ-013 SHALL have port dbus_rdata  input  XLEN  data-bus read word.
REQ-014 SHALL have port wb_stall  output  1  holds MEM and earlier stages.
REQ-015 SHALL have port reg_write  output  1  regfile write enable.
REQ-016 SHALL have port reg_regid  output  REG_AW  regfile write index.
REQ-017 SHALL have port reg_writedata  output  XLEN  regfile write data.
REQ-018 SHALL have port wb_retire  output  1  one-cycle pulse per retired instruction.

Function
REQ-019 SHALL implement FSM states IDLE, WRITE, LOAD_WAIT.
REQ-020 SHALL capture MEM inputs on a posedge where mem_valid=1 and wb_stall=0 (state IDLE or WRITE).
REQ-021 On capture with mem_load=0, SHALL enter WRITE next cycle with reg_writedata=mem_alu_result.
REQ-022 On capture with mem_load=1, SHALL enter LOAD_WAIT with reg_write=0.
REQ-023 wb_stall SHALL equal (state==LOAD_WAIT), combinational from state only.
REQ-024 In LOAD_WAIT, dbus_rvalid=1 SHALL register formatted dbus_rdata and move to WRITE; otherwise stay, no timeout.
REQ-025 dbus_rvalid in IDLE or WRITE SHALL be ignored.
REQ-026 In WRITE: reg_write=captured reg_write AND regid!=0, wb_retire=1, for exactly one cycle; all outputs registered.
REQ-027 From WRITE: capture → WRITE/LOAD_WAIT back-to-back, else IDLE; non-load throughput one per cycle.
REQ-028 Load format: LB(000)/LBU(100) byte at mem_addr_lo*8, sign/zero-extended; LH(001)/LHU(101) half at mem_addr_lo[1]*16, sign/zero-extended, mem_addr_lo[0] ignored; LW(010) and all other codes pass word unchanged.
REQ-029 mem_valid while wb_stall=1 SHALL not be captured; MEM holds it.
REQ-030 dbus_rvalid and mem_valid both high in LOAD_WAIT: load completes, new instruction captured next cycle (in WRITE).
REQ-031 reg_write=0 in IDLE and LOAD_WAIT; reg_regid/reg_writedata hold last value.

Reset
REQ-032 rst SHALL asynchronously force IDLE, reg_write=0, wb_retire=0, reg_regid=0, reg_writedata=0, wb_stall=0.
REQ-033 Reset during LOAD_WAIT SHALL drop the pending load; a later dbus_rvalid SHALL be ignored.

Structure
REQ-034 Load funct3 encodings, FSM state enum, XLEN/REG_AW ranges SHALL live in the shared core header/package.
REQ-035 Load extraction/extension SHALL be a combinational sub-module load_formatter.

Verification
REQ-036 ALU: mem_valid, reg_write=1, regid=5, result=0x1234 → next cycle reg_write=1, regid=5, data=0x1234, wb_retire=1.
REQ-037 x0: regid=0, reg_write=1 → reg_write=0, wb_retire=1.
REQ-038 LB: addr_lo=3, rvalid two cycles after capture, rdata=0x80FF_FF00 → wb_stall high 2 cycles, then data=0xFFFF_FF80.
REQ-039 LHU addr_lo=2 rdata=0xBEEF_0000 → 0x0000_BEEF; LH same → 0xFFFF_BEEF.
REQ-040 Back-to-back ALU then load then ALU with rvalid+mem_valid same cycle → three writes in order, no lost/duplicate retire.
REQ-041 rst asserted in LOAD_WAIT, later rvalid=1 → no reg_write, wb_stall=0.
